tug_playfield: RTL and testbench

TUG_PLAYFIELD -- requirements
Module: tug_playfield

---
 rtl/tug_playfield.sv | 116 +++++++++++
 tb/tb_tug_playfield.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tug_playfield.sv
// rtl/tug_playfield.sv - two-player tug-of-war playfield with synchronized keys, win FSM and saturating scores
module tug_playfield (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       KeyL,
  input  logic       KeyR,
  input  logic       Restart,
  output logic [9:0] LEDR,
  output logic       L,
  output logic       R,
  output logic [1:0] Winner,
  output logic [2:0] ScoreL,
  output logic [2:0] ScoreR
);

  // Winner is read straight off the state register, so the encoding doubles as the output code.
  typedef enum logic [1:0] {
    PLAY  = 2'b00,
    WIN_L = 2'b01,
    WIN_R = 2'b10
  } state_t;

  localparam logic [3:0] POS_HOME = 4'd5;
  localparam logic [3:0] POS_LMAX = 4'd9;
  localparam logic [3:0] POS_RMIN = 4'd1;
  localparam logic [2:0] SCORE_MAX = 3'd7;

  logic   sync_l1, sync_l2, dly_l;
  logic   sync_r1, sync_r2, dly_r;
  state_t state_q, state_d;
  logic [3:0] pos_q, pos_d;
  logic [2:0] score_l_q, score_l_d;
  logic [2:0] score_r_q, score_r_d;

  // Two-flop synchronizers on the raw buttons, followed by a one-cycle delay for edge detection.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync_l1 <= 1'b0;
      sync_l2 <= 1'b0;
      dly_l   <= 1'b0;
      sync_r1 <= 1'b0;
      sync_r2 <= 1'b0;
      dly_r   <= 1'b0;
    end else begin
      sync_l1 <= KeyL;
      sync_l2 <= sync_l1;
      dly_l   <= sync_l2;
      sync_r1 <= KeyR;
      sync_r2 <= sync_r1;
      dly_r   <= sync_r2;
    end
  end

  // Rising-edge pulses: a held key yields one pulse and must drop for a sampled cycle to re-arm.
  assign L = sync_l2 & ~dly_l;
  assign R = sync_r2 & ~dly_r;

  // Game state, marker position and scores.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= PLAY;
      pos_q     <= POS_HOME;
      score_l_q <= 3'd0;
      score_r_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
    end
  end

  // Next-state: simultaneous or absent pulses leave play untouched; win states only wait for Restart.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    case (state_q)
      PLAY: begin
        if (L && !R) begin
          if (pos_q < POS_LMAX) begin
            pos_d = pos_q + 4'd1;
          end else begin
            state_d = WIN_L;
            if (score_l_q != SCORE_MAX) score_l_d = score_l_q + 3'd1;
          end
        end else if (R && !L) begin
          if (pos_q > POS_RMIN) begin
            pos_d = pos_q - 4'd1;
          end else begin
            state_d = WIN_R;
            if (score_r_q != SCORE_MAX) score_r_d = score_r_q + 3'd1;
          end
        end
      end
      WIN_L, WIN_R: begin
        if (Restart) begin
          state_d = PLAY;
          pos_d   = POS_HOME;
        end
      end
      default: begin
        state_d = PLAY;
        pos_d   = POS_HOME;
      end
    endcase
  end

  // Outputs decoded from registers; LEDR[0] is never lit because pos never reaches 0.
  assign LEDR   = 10'd1 << pos_q;
  assign Winner = state_q;
  assign ScoreL = score_l_q;
  assign ScoreR = score_r_q;

endmodule

// File: tb/tb_tug_playfield.sv
// tb/tb_tug_playfield.sv - self-checking bench for tug_playfield against a game-rule reference model
module tb_tug_playfield;

  logic       Clock;
  logic       Reset;
  logic       KeyL;
  logic       KeyR;
  logic       Restart;
  logic [9:0] LEDR;
  logic       L;
  logic       R;
  logic [1:0] Winner;
  logic [2:0] ScoreL;
  logic [2:0] ScoreR;

  int total = 0;
  int bad   = 0;

  // reference model: game in plain integers, keys as a history of sampled levels
  int   m_pos;
  int   m_win;      // 0 playing, 1 left won, 2 right won
  int   m_sl, m_sr;
  logic hl[4];      // hl[0] = level sampled at the newest edge
  logic hr[4];
  logic m_l, m_r;

  tug_playfield dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .KeyL    (KeyL),
    .KeyR    (KeyR),
    .Restart (Restart),
    .LEDR    (LEDR),
    .L       (L),
    .R       (R),
    .Winner  (Winner),
    .ScoreL  (ScoreL),
    .ScoreR  (ScoreR)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic logic [9:0] exp_led();
    logic [9:0] v;
    v = '0;
    v[m_pos] = 1'b1;
    return v;
  endfunction

  function automatic logic [20:0] exp_vec();
    return {exp_led(), m_l, m_r, 2'(m_win), 3'(m_sl), 3'(m_sr)};
  endfunction

  task automatic model_reset();
    m_pos = 5;
    m_win = 0;
    m_sl  = 0;
    m_sr  = 0;
    for (int i = 0; i < 4; i++) begin
      hl[i] = 1'b0;
      hr[i] = 1'b0;
    end
    m_l = 1'b0;
    m_r = 1'b0;
  endtask

  // Drive inputs, take one rising edge, advance the model, then settle 1 time unit past the edge.
  // A press first sampled at edge k is seen by the game at edge k+2 and is visible as a pulse after k+1.
  task automatic step(input logic kl, input logic kr, input logic rs);
    logic pl, pr;
    KeyL    = kl;
    KeyR    = kr;
    Restart = rs;
    @(posedge Clock);
    if (!Reset) begin
      model_reset();
    end else begin
      for (int i = 3; i > 0; i--) begin
        hl[i] = hl[i-1];
        hr[i] = hr[i-1];
      end
      hl[0] = kl;
      hr[0] = kr;
      pl = hl[2] & ~hl[3];
      pr = hr[2] & ~hr[3];
      if (m_win == 0) begin
        if (pl && !pr) begin
          if (m_pos < 9) m_pos++;
          else begin
            m_win = 1;
            if (m_sl < 7) m_sl++;
          end
        end else if (pr && !pl) begin
          if (m_pos > 1) m_pos--;
          else begin
            m_win = 2;
            if (m_sr < 7) m_sr++;
          end
        end
      end else if (rs) begin
        m_win = 0;
        m_pos = 5;
      end
      m_l = hl[1] & ~hl[2];
      m_r = hr[1] & ~hr[2];
    end
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    #1;
    model_reset();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    Reset = 1'b1;
  endtask

  task automatic press(input logic left);
    for (int i = 0; i < 3; i++) step(left, ~left, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({LEDR, L, R, Winner, ScoreL, ScoreR} !== {10'b0000100000, 1'b0, 1'b0, 2'b00, 3'd0, 3'd0}) begin
      bad++;
      $display("FAIL reset_values: got %b required %b", {LEDR, L, R, Winner, ScoreL, ScoreR},
               {10'b0000100000, 1'b0, 1'b0, 2'b00, 3'd0, 3'd0});
    end
  endtask

  task automatic test_single_press();
    int pulses;
    do_reset();
    pulses = 0;
    step(1'b1, 1'b0, 1'b0);
    pulses += int'(L);
    total++;
    if (L !== 1'b0 || LEDR !== 10'b0000100000) begin
      bad++;
      $display("FAIL press_edge_k: L=%b LEDR=%b required L=0 LEDR=0000100000", L, LEDR);
    end
    step(1'b1, 1'b0, 1'b0);
    pulses += int'(L);
    total++;
    if (L !== 1'b1 || LEDR !== 10'b0000100000) begin
      bad++;
      $display("FAIL press_edge_k1: L=%b LEDR=%b required L=1 LEDR=0000100000", L, LEDR);
    end
    step(1'b1, 1'b0, 1'b0);
    pulses += int'(L);
    total++;
    if (L !== 1'b0 || LEDR !== 10'b0001000000) begin
      bad++;
      $display("FAIL press_edge_k2: L=%b LEDR=%b required L=0 LEDR=0001000000", L, LEDR);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0);
      pulses += int'(L);
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL press_pulse_count: got %0d required 1", pulses);
    end
  endtask

  task automatic test_win_left();
    do_reset();
    for (int i = 0; i < 4; i++) press(1'b1);
    total++;
    if (LEDR !== 10'b1000000000 || Winner !== 2'b00) begin
      bad++;
      $display("FAIL left_edge: LEDR=%b Winner=%b required 1000000000 00", LEDR, Winner);
    end
    press(1'b1);
    total++;
    if (LEDR !== 10'b1000000000 || Winner !== 2'b01 || ScoreL !== 3'd1 || ScoreR !== 3'd0) begin
      bad++;
      $display("FAIL left_win: LEDR=%b Winner=%b ScoreL=%0d ScoreR=%0d required 1000000000 01 1 0",
               LEDR, Winner, ScoreL, ScoreR);
    end
    press(1'b0);
    press(1'b0);
    press(1'b1);
    total++;
    if (LEDR !== 10'b1000000000 || Winner !== 2'b01 || ScoreL !== 3'd1 || ScoreR !== 3'd0) begin
      bad++;
      $display("FAIL win_frozen: LEDR=%b Winner=%b ScoreL=%0d ScoreR=%0d required 1000000000 01 1 0",
               LEDR, Winner, ScoreL, ScoreR);
    end
  endtask

  task automatic test_restart();
    step(1'b0, 1'b0, 1'b1);
    Restart = 1'b0;
    total++;
    if (Winner !== 2'b00 || LEDR !== 10'b0000100000 || ScoreL !== 3'd1) begin
      bad++;
      $display("FAIL restart: Winner=%b LEDR=%b ScoreL=%0d required 00 0000100000 1", Winner, LEDR, ScoreL);
    end
    press(1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (LEDR !== 10'b0000010000 || Winner !== 2'b00) begin
      bad++;
      $display("FAIL restart_in_play: LEDR=%b Winner=%b required 0000010000 00", LEDR, Winner);
    end
  endtask

  task automatic test_simultaneous();
    int both;
    do_reset();
    press(1'b1);
    both = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (L === 1'b1 && R === 1'b1) both++;
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    total++;
    if (both != 1 || LEDR !== 10'b0001000000) begin
      bad++;
      $display("FAIL simultaneous: both_cycles=%0d LEDR=%b required 1 0001000000", both, LEDR);
    end
  endtask

  task automatic test_score_saturation();
    do_reset();
    for (int w = 1; w <= 8; w++) begin
      for (int i = 0; i < 5; i++) press(1'b0);
      total++;
      if (Winner !== 2'b10 || LEDR !== 10'b0000000010 || ScoreR !== 3'((w > 7) ? 7 : w)) begin
        bad++;
        $display("FAIL right_win_%0d: Winner=%b LEDR=%b ScoreR=%0d required 10 0000000010 %0d",
                 w, Winner, LEDR, ScoreR, (w > 7) ? 7 : w);
      end
      step(1'b0, 1'b0, 1'b1);
    end
    Restart = 1'b0;
    total++;
    if (ScoreL !== 3'd0 || ScoreR !== 3'd7) begin
      bad++;
      $display("FAIL score_sat: ScoreL=%0d ScoreR=%0d required 0 7", ScoreL, ScoreR);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) press(1'b1);
    total++;
    if (LEDR !== 10'b0100000000) begin
      bad++;
      $display("FAIL pos8: LEDR=%b required 0100000000", LEDR);
    end
    #3;
    Reset = 1'b0;
    #1;
    total++;
    if ({LEDR, L, R, Winner, ScoreL, ScoreR} !== {10'b0000100000, 1'b0, 1'b0, 2'b00, 3'd0, 3'd0}) begin
      bad++;
      $display("FAIL async_reset: got %b required %b", {LEDR, L, R, Winner, ScoreL, ScoreR},
               {10'b0000100000, 1'b0, 1'b0, 2'b00, 3'd0, 3'd0});
    end
    model_reset();
    step(1'b0, 1'b0, 1'b0);
    Reset = 1'b1;
  endtask

  task automatic test_held_across_reset();
    int pulses;
    int first;
    Reset = 1'b0;
    #1;
    model_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    Reset = 1'b1;
    pulses = 0;
    first  = -1;
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (L === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    total++;
    if (pulses != 1 || first != 2 || LEDR !== 10'b0001000000) begin
      bad++;
      $display("FAIL held_reset: pulses=%0d first_edge=%0d LEDR=%b required 1 2 0001000000",
               pulses, first, LEDR);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic kl, kr, rs;
    int   bias;
    int   errs;
    do_reset();
    errs = 0;
    for (int seg = 0; seg < 40; seg++) begin
      bias = $urandom_range(0, 2);
      for (int c = 0; c < 40; c++) begin
        kl = ($urandom_range(0, 9) < ((bias == 0) ? 6 : (bias == 1) ? 2 : 4));
        kr = ($urandom_range(0, 9) < ((bias == 1) ? 6 : (bias == 0) ? 2 : 4));
        rs = ($urandom_range(0, 15) == 0);
        step(kl, kr, rs);
        total++;
        if ({LEDR, L, R, Winner, ScoreL, ScoreR} !== exp_vec()) begin
          bad++;
          errs++;
          if (errs <= 10)
            $display("FAIL random_seg%0d_cyc%0d: got %b required %b", seg, c,
                     {LEDR, L, R, Winner, ScoreL, ScoreR}, exp_vec());
        end
      end
    end
  endtask

  initial begin
    Reset   = 1'b0;
    KeyL    = 1'b0;
    KeyR    = 1'b0;
    Restart = 1'b0;
    model_reset();
    test_reset();
    test_single_press();
    test_win_left();
    test_restart();
    test_simultaneous();
    test_score_saturation();
    test_async_reset();
    test_held_across_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
